fifo_write_logic: RTL and testbench

- Write-side controller of the router's shared packet buffer; the producer that the packet read/dispatch controller consumes from.
- Accepts byte-serial ingress packets via valid/ready.
- Obtains a free slot index from the index ring, writes the packet bytes into that unified-memory slot, then publishes it by advancing the write pointer.
- The read side receives the pointer as a synchronized copy and later returns the freed slot into the same ring entry.

---
 rtl/fifo_write_logic.sv | 152 +++++++++++++++
 tb/tb_fifo_write_logic.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_logic.sv
// Write-side controller of the shared packet buffer: takes a free slot from the
// index ring, stores one byte-serial packet into it, then publishes it via wptr.
module fifo_write_logic #(
    parameter int DEPTH     = 4,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [UWIDTH-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [PTR_SZ:0]      rq2_rptr,
    output logic [PTR_SZ:0]      wptr,
    output logic                 full,
    output logic                 iread_en,
    output logic [PTR_SZ-1:0]    iaddr,
    input  logic [PTR_SZ-1:0]    idata_in,
    output logic                 uwrite_en,
    output logic [PTR_SZ-1:0]    uaddr,
    output logic [PTR_IN_SZ-1:0] uaddr_in,
    output logic [UWIDTH-1:0]    uwdata,
    output logic                 err_drop,
    output logic [2:0]           dbg_state
);

    // Handshake: a byte is transferred on every rising clk2 edge where
    // in_valid && in_ready; upstream holds in_data/in_last until then.
    typedef enum logic [2:0] {IDLE, FETCH, RECV, DROP, COMMIT} state_t;

    localparam int unsigned          SLOT_MASK = DEPTH - 1;
    localparam logic [PTR_IN_SZ-1:0] CNT_MAX   = '1;

    state_t                 state_q, state_d;
    logic [PTR_SZ:0]        wptr_q, wptr_d;
    logic                   iread_en_q, iread_en_d;
    logic [PTR_SZ-1:0]      iaddr_q, iaddr_d;
    logic                   uwrite_en_q, uwrite_en_d;
    logic [PTR_SZ-1:0]      uaddr_q, uaddr_d;
    logic [PTR_IN_SZ-1:0]   uaddr_in_q, uaddr_in_d;
    logic [UWIDTH-1:0]      uwdata_q, uwdata_d;
    logic                   err_drop_q, err_drop_d;
    logic [PTR_SZ-1:0]      slot_q, slot_d;
    logic [PTR_IN_SZ-1:0]   byte_cnt_q, byte_cnt_d;
    logic                   hs;

    assign full     = (wptr_q[PTR_SZ] != rq2_rptr[PTR_SZ]) &&
                      (wptr_q[PTR_SZ-1:0] == rq2_rptr[PTR_SZ-1:0]);
    assign in_ready = (state_q == RECV) || (state_q == DROP);
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        iread_en_d  = 1'b0;
        iaddr_d     = iaddr_q;
        uwrite_en_d = 1'b0;
        uaddr_d     = uaddr_q;
        uaddr_in_d  = uaddr_in_q;
        uwdata_d    = uwdata_q;
        err_drop_d  = 1'b0;
        slot_d      = slot_q;
        byte_cnt_d  = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    iread_en_d = 1'b1;
                    iaddr_d    = wptr_q[PTR_SZ-1:0] & SLOT_MASK[PTR_SZ-1:0];
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                slot_d     = idata_in;
                byte_cnt_d = '0;
                state_d    = RECV;
            end
            RECV: begin
                if (hs) begin
                    uwrite_en_d = 1'b1;
                    uaddr_d     = slot_q;
                    uaddr_in_d  = byte_cnt_q;
                    uwdata_d    = in_data;
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                    if (in_last) begin
                        // A lone header byte carries no dest_id: discard it.
                        if (byte_cnt_q == '0) begin
                            err_drop_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d    = COMMIT;
                        end
                    end else if (byte_cnt_q == CNT_MAX) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (hs && in_last) begin
                    err_drop_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            COMMIT: begin
                // Publish only after the final byte's write strobe is out.
                wptr_d  = wptr_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            iread_en_q  <= 1'b0;
            iaddr_q     <= '0;
            uwrite_en_q <= 1'b0;
            uaddr_q     <= '0;
            uaddr_in_q  <= '0;
            uwdata_q    <= '0;
            err_drop_q  <= 1'b0;
            slot_q      <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            iread_en_q  <= iread_en_d;
            iaddr_q     <= iaddr_d;
            uwrite_en_q <= uwrite_en_d;
            uaddr_q     <= uaddr_d;
            uaddr_in_q  <= uaddr_in_d;
            uwdata_q    <= uwdata_d;
            err_drop_q  <= err_drop_d;
            slot_q      <= slot_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign wptr      = wptr_q;
    assign iread_en  = iread_en_q;
    assign iaddr     = iaddr_q;
    assign uwrite_en = uwrite_en_q;
    assign uaddr     = uaddr_q;
    assign uaddr_in  = uaddr_in_q;
    assign uwdata    = uwdata_q;
    assign err_drop  = err_drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_write_logic.sv
// Bench for fifo_write_logic: directed scenarios with random packet bodies,
// checked against a packet-level model of slots, offsets, pointer and drops.
module tb_fifo_write_logic;

    localparam int DEPTH     = 4;
    localparam int UWIDTH    = 8;
    localparam int PTR_SZ    = 2;
    localparam int PTR_IN_SZ = 4;
    localparam int MAX_BYTES = 2 ** PTR_IN_SZ;

    logic                 clk2;
    logic                 rst;
    logic                 in_valid;
    logic [UWIDTH-1:0]    in_data;
    logic                 in_last;
    logic                 in_ready;
    logic [PTR_SZ:0]      rq2_rptr;
    logic [PTR_SZ:0]      wptr;
    logic                 full;
    logic                 iread_en;
    logic [PTR_SZ-1:0]    iaddr;
    logic [PTR_SZ-1:0]    idata_in;
    logic                 uwrite_en;
    logic [PTR_SZ-1:0]    uaddr;
    logic [PTR_IN_SZ-1:0] uaddr_in;
    logic [UWIDTH-1:0]    uwdata;
    logic                 err_drop;
    logic [2:0]           dbg_state;

    fifo_write_logic #(
        .DEPTH(DEPTH), .UWIDTH(UWIDTH), .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)
    ) dut (
        .clk2(clk2), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rq2_rptr(rq2_rptr), .wptr(wptr),
        .full(full), .iread_en(iread_en), .iaddr(iaddr), .idata_in(idata_in),
        .uwrite_en(uwrite_en), .uaddr(uaddr), .uaddr_in(uaddr_in), .uwdata(uwdata),
        .err_drop(err_drop), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // index ring model: asynchronous read of a fixed slot permutation
    logic [PTR_SZ-1:0] ring [DEPTH];
    assign idata_in = ring[iaddr];

    // scoreboard
    int n_cmp = 0;
    int n_mis = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [PTR_SZ:0] wptr_m = '0;
    logic [PTR_SZ+PTR_IN_SZ+UWIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk2) begin
        if (rst) begin
            if (err_drop) err_seen++;
            if (uwrite_en) begin
                if (exp_q.size() == 0)
                    check("write_unexpected", 32'(uwrite_en), 32'd0);
                else
                    check("write", 32'({uaddr, uaddr_in, uwdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic send_pkt(input int len, input bit bubbles, input bit use_fixed,
                            input logic [31:0] fixed);
        logic [UWIDTH-1:0] b;
        logic [PTR_SZ-1:0] slot;
        int i;
        int guard;
        i = 0;
        guard = 0;
        slot = ring[wptr_m[PTR_SZ-1:0]];
        b = use_fixed ? fixed[31:24] : UWIDTH'($urandom);
        while (i < len && guard < 1000) begin
            @(negedge clk2);
            guard++;
            in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = b;
            in_last  = (i == len - 1);
            if (in_valid && in_ready) begin
                if (i < MAX_BYTES) exp_q.push_back({slot, PTR_IN_SZ'(i), b});
                i++;
                b = use_fixed ? fixed[8*(3-(i%4)) +: 8] : UWIDTH'($urandom);
            end
        end
        check("send_done", 32'(i), 32'(len));
        if (len == 1 || len > MAX_BYTES) err_exp++;
        else wptr_m = wptr_m + 1'b1;
        @(negedge clk2);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic settle_check();
        logic [PTR_SZ:0] used;
        repeat (3) @(negedge clk2);
        used = wptr_m - rq2_rptr;
        check("wptr", 32'(wptr), 32'(wptr_m));
        check("err_count", 32'(err_seen), 32'(err_exp));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        check("full", 32'(full), 32'(used == DEPTH));
    endtask

    task automatic wait_fetch(input logic [PTR_SZ-1:0] exp_addr);
        int n;
        n = 0;
        do begin
            @(negedge clk2);
            n++;
        end while (!iread_en && n < 20);
        check("fetch_seen", 32'(iread_en), 32'd1);
        check("fetch_iaddr", 32'(iaddr), 32'(exp_addr));
    endtask

    initial begin
        ring[0] = 2'd2; ring[1] = 2'd3; ring[2] = 2'd0; ring[3] = 2'd1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        rq2_rptr = '0;

        // reset values
        repeat (2) @(negedge clk2);
        check("rst_wptr", 32'(wptr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_iread_en", 32'(iread_en), 32'd0);
        check("rst_uwrite_en", 32'(uwrite_en), 32'd0);
        check("rst_err_drop", 32'(err_drop), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b1;

        // first packet into slot 2 with exact write/publish timing
        send_pkt(4, 1'b0, 1'b1, 32'h0405AABB);
        check("t1_last_wr_en", 32'(uwrite_en), 32'd1);
        check("t1_last_uaddr", 32'(uaddr), 32'd2);
        check("t1_last_off", 32'(uaddr_in), 32'd3);
        check("t1_last_data", 32'(uwdata), 32'hBB);
        check("t1_wptr_hold", 32'(wptr), 32'd0);
        @(negedge clk2);
        check("t1_wptr_pub", 32'(wptr), 32'd1);
        check("t1_no_err", 32'(err_drop), 32'd0);
        settle_check();

        // fill to full with the read side parked at 0
        for (int k = 0; k < 3; k++) begin
            send_pkt($urandom_range(2, MAX_BYTES), 1'b0, 1'b0, 32'd0);
            settle_check();
        end
        check("t2_wptr_full", 32'(wptr), 32'b100);
        repeat (4) @(negedge clk2);
        check("t2_stall_ready", 32'(in_ready), 32'd0);
        check("t2_stall_iread", 32'(iread_en), 32'd0);
        check("t2_stall_full", 32'(full), 32'd1);
        rq2_rptr = 3'd1;
        @(negedge clk2);
        check("t2_resume_iread", 32'(iread_en), 32'd1);
        check("t2_resume_iaddr", 32'(iaddr), 32'd0);

        // runt packet: dropped, slot reused
        send_pkt(1, 1'b0, 1'b0, 32'd0);
        wait_fetch(wptr_m[PTR_SZ-1:0]);
        settle_check();

        // oversize packet: 16 writes then discard
        send_pkt(20, 1'b0, 1'b0, 32'd0);
        settle_check();

        // random packets with valid bubbles and a moving read pointer
        for (int k = 0; k < 8; k++) begin
            rq2_rptr = wptr_m - PTR_SZ'($urandom_range(0, 2));
            send_pkt($urandom_range(1, 20), 1'b1, 1'b0, 32'd0);
            settle_check();
        end

        // asynchronous reset in the middle of a packet
        begin
            int n;
            logic [PTR_SZ-1:0] slot;
            logic [UWIDTH-1:0] b;
            n = 0;
            do begin
                @(negedge clk2);
                n++;
            end while (!in_ready && n < 20);
            check("t6_ready_seen", 32'(in_ready), 32'd1);
            slot = ring[wptr_m[PTR_SZ-1:0]];
            for (int i = 0; i < 2; i++) begin
                if (i > 0) @(negedge clk2);
                b = UWIDTH'($urandom);
                in_valid = 1'b1;
                in_data = b;
                in_last = 1'b0;
                exp_q.push_back({slot, PTR_IN_SZ'(i), b});
            end
            @(negedge clk2);
            in_valid = 1'b0;
            #2 rst = 1'b0;
            #1;
            check("t6_wptr", 32'(wptr), 32'd0);
            check("t6_in_ready", 32'(in_ready), 32'd0);
            check("t6_uwrite_en", 32'(uwrite_en), 32'd0);
            check("t6_uaddr", 32'(uaddr), 32'd0);
            check("t6_uaddr_in", 32'(uaddr_in), 32'd0);
            check("t6_uwdata", 32'(uwdata), 32'd0);
            check("t6_iread_en", 32'(iread_en), 32'd0);
            check("t6_iaddr", 32'(iaddr), 32'd0);
            check("t6_err_drop", 32'(err_drop), 32'd0);
            exp_q.delete();
            wptr_m = '0;
            rq2_rptr = '0;
            @(negedge clk2);
            rst = 1'b1;
            wait_fetch(2'd0);
            check("t6_wptr_after", 32'(wptr), 32'd0);
            send_pkt(5, 1'b1, 1'b0, 32'd0);
            settle_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
